// File: rtl/sin_cos.sv
// Streaming CORDIC (rotation mode): signed phase in, cosine and sine out.
// One sample per clock; fixed latency of Width cycles through fold, iterations, round and output stages.
module sin_cos #(
    parameter int Width = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    phase_valid,
    input  logic signed [Width-1:0] phase,
    output logic                    sin_cos_valid,
    output logic signed [Width-1:0] cos,
    output logic signed [Width-1:0] sin
);

    localparam int ITER = Width - 2;
    localparam int G    = 4;
    localparam int XW   = Width + G + 2;
    localparam int ZW   = Width + G;
    localparam int XF   = Width - 2 + G;
    localparam int ZF   = Width - 3 + G;

    typedef logic [ITER-1:0][ZW-1:0] angle_rom_t;

    // Beyond i=9 the difference between atan(2^-i) and 2^-i is far below any practical LSB.
    function automatic real atan_pow2(input int i);
        case (i)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            default: return 2.0 ** (-i);
        endcase
    endfunction

    function automatic logic signed [ZW-1:0] scale_z(input real v);
        return ZW'($rtoi(v * (2.0 ** ZF) + 0.5));
    endfunction

    function automatic angle_rom_t build_rom();
        angle_rom_t rom;
        for (int i = 0; i < ITER; i++) begin
            rom[i] = scale_z(atan_pow2(i));
        end
        return rom;
    endfunction

    localparam angle_rom_t              ATAN_ROM   = build_rom();
    localparam logic signed [ZW-1:0]    PI_Z       = scale_z(3.141592653589793);
    localparam logic signed [Width-1:0] HALF_PI_PH = Width'($rtoi(1.5707963267948966 * (2.0 ** (Width - 3)) + 0.5));
    localparam logic signed [XW-1:0]    X_INIT     = XW'($rtoi(0.6072529350 * (2.0 ** XF) + 0.5));
    localparam logic signed [XW-1:0]    ROUND_HALF = XW'(2 ** (G - 1));
    localparam logic signed [XW-1:0]    OUT_MAX    = XW'(2 ** (Width - 2));

    // Undo the fold, drop the guard bits with round-half-up, and saturate to +/-1.0.
    function automatic logic signed [Width-1:0] round_clamp(input logic signed [XW-1:0] v,
                                                            input logic neg);
        logic signed [XW-1:0] s;
        logic signed [XW-1:0] r;
        s = neg ? -v : v;
        r = (s + ROUND_HALF) >>> G;
        if (r > OUT_MAX) begin
            r = OUT_MAX;
        end else if (r < -OUT_MAX) begin
            r = -OUT_MAX;
        end
        return r[Width-1:0];
    endfunction

    logic signed [XW-1:0]    x_pipe [ITER+1];
    logic signed [XW-1:0]    y_pipe [ITER+1];
    logic signed [ZW-1:0]    z_pipe [ITER+1];
    logic [ITER:0]           flip_pipe;
    logic [ITER:0]           valid_pipe;
    logic signed [ZW-1:0]    phase_z;
    logic signed [ZW-1:0]    z_fold;
    logic                    fold;
    logic signed [Width-1:0] cos_f;
    logic signed [Width-1:0] sin_f;
    logic                    valid_f;

    assign phase_z = {phase, {G{1'b0}}};

    // Map phase into [-pi/2, +pi/2]; the half-turn is restored by negating both results.
    always_comb begin
        z_fold = phase_z;
        fold   = 1'b0;
        if (phase > HALF_PI_PH) begin
            z_fold = phase_z - PI_Z;
            fold   = 1'b1;
        end else if (phase < -HALF_PI_PH) begin
            z_fold = phase_z + PI_Z;
            fold   = 1'b1;
        end
    end

    // Data path runs every cycle; only the valid bits decide what reaches the outputs.
    always_ff @(posedge clk) begin
        x_pipe[0]    <= X_INIT;
        y_pipe[0]    <= '0;
        z_pipe[0]    <= z_fold;
        flip_pipe    <= {flip_pipe[ITER-1:0], fold};
        for (int i = 0; i < ITER; i++) begin
            if (!z_pipe[i][ZW-1]) begin
                x_pipe[i+1] <= x_pipe[i] - (y_pipe[i] >>> i);
                y_pipe[i+1] <= y_pipe[i] + (x_pipe[i] >>> i);
                z_pipe[i+1] <= z_pipe[i] - $signed(ATAN_ROM[i]);
            end else begin
                x_pipe[i+1] <= x_pipe[i] + (y_pipe[i] >>> i);
                y_pipe[i+1] <= y_pipe[i] - (x_pipe[i] >>> i);
                z_pipe[i+1] <= z_pipe[i] + $signed(ATAN_ROM[i]);
            end
        end
        cos_f <= round_clamp(x_pipe[ITER], flip_pipe[ITER]);
        sin_f <= round_clamp(y_pipe[ITER], flip_pipe[ITER]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe    <= '0;
            valid_f       <= 1'b0;
            sin_cos_valid <= 1'b0;
            cos           <= '0;
            sin           <= '0;
        end else begin
            valid_pipe    <= {valid_pipe[ITER-1:0], phase_valid};
            valid_f       <= valid_pipe[ITER];
            sin_cos_valid <= valid_f;
            if (valid_f) begin
                cos <= cos_f;
                sin <= sin_f;
            end
        end
    end

endmodule

// File: tb/tb_sin_cos.sv
// Directed bench for sin_cos: axis/diagonal points, valid gaps, resets and a full phase sweep.
module tb_sin_cos;

    localparam int W = 16;
    localparam int L = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                phase_valid;
    logic signed [W-1:0] phase;
    logic                sin_cos_valid;
    logic signed [W-1:0] cos_val;
    logic signed [W-1:0] sin_val;

    int compared   = 0;
    int mismatched = 0;

    sin_cos #(.Width(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .phase_valid   (phase_valid),
        .phase         (phase),
        .sin_cos_valid (sin_cos_valid),
        .cos           (cos_val),
        .sin           (sin_val)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input int ph);
        phase_valid = v;
        phase       = W'(ph);
        step();
    endtask

    task automatic check_output(input string tag, input int observed, input int expected, input int tol);
        int diff;
        diff = observed - expected;
        compared++;
        assert ((diff <= tol && diff >= -tol) === 1'b1)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Single valid pulse; nothing may appear before L cycles, the result must appear exactly at L.
    task automatic run_pulse(input string tag, input int ph, input int exp_cos, input int exp_sin);
        int early;
        early = 0;
        apply_stimulus(1'b1, ph);
        for (int k = 1; k < L; k++) begin
            apply_stimulus(1'b0, 0);
            if (sin_cos_valid !== 1'b0) early = 1;
        end
        check_output({tag, "_early_valid"}, early, 0, 0);
        apply_stimulus(1'b0, 0);
        check_output({tag, "_valid"}, int'(sin_cos_valid), 1, 0);
        check_output({tag, "_cos"}, cos_val, exp_cos, 4);
        check_output({tag, "_sin"}, sin_val, exp_sin, 4);
    endtask

    function automatic int round_real(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    initial begin
        int idle_bad;
        int bad_valid;
        int sweep_q[$];
        int gap_v   [5] = '{1, 0, 1, 1, 0};
        int gap_ph  [5] = '{0, 777, 12868, 25736, -5000};
        int gap_cos [5] = '{16384, 16384, 0, -16384, -16384};
        int gap_sin [5] = '{0, 0, 16384, 0, 0};

        rst         = 1'b1;
        phase_valid = 1'b0;
        phase       = '0;
        repeat (3) step();
        check_output("reset_valid", int'(sin_cos_valid), 0, 0);
        check_output("reset_cos", cos_val, 0, 0);
        check_output("reset_sin", sin_val, 0, 0);

        rst = 1'b0;
        idle_bad = 0;
        repeat (L + 4) begin
            apply_stimulus(1'b0, 0);
            if (sin_cos_valid !== 1'b0 || cos_val !== '0 || sin_val !== '0) idle_bad = 1;
        end
        check_output("powerup_idle", idle_bad, 0, 0);

        run_pulse("zero", 0, 16384, 0);
        run_pulse("half_pi", 12868, 0, 16384);
        run_pulse("neg_pi", -25736, -16384, 0);
        run_pulse("pi_4", 6434, 11585, 11585);
        run_pulse("neg_3pi_4", -19302, -11585, -11585);

        for (int j = 0; j < 5; j++) apply_stimulus(gap_v[j][0], gap_ph[j]);
        repeat (L - 5) apply_stimulus(1'b0, 0);
        for (int j = 0; j < 5; j++) begin
            apply_stimulus(1'b0, 0);
            check_output($sformatf("gap%0d_valid", j), int'(sin_cos_valid), gap_v[j], 0);
            check_output($sformatf("gap%0d_cos", j), cos_val, gap_cos[j], 4);
            check_output($sformatf("gap%0d_sin", j), sin_val, gap_sin[j], 4);
        end
        repeat (L) apply_stimulus(1'b0, 0);

        for (int j = 0; j < 10; j++) apply_stimulus(1'b1, 6434);
        rst = 1'b1;
        apply_stimulus(1'b0, 0);
        rst = 1'b0;
        check_output("midreset_valid", int'(sin_cos_valid), 0, 0);
        check_output("midreset_cos", cos_val, 0, 0);
        check_output("midreset_sin", sin_val, 0, 0);
        run_pulse("after_reset", -12868, 0, -16384);

        for (int p = -25736; p <= 25736; p += 256) sweep_q.push_back(p);
        for (int p = 25720 - 256; p >= -25736; p -= 256) sweep_q.push_back(p);
        bad_valid = 0;
        for (int k = 0; k < sweep_q.size() + L; k++) begin
            if (k < sweep_q.size()) apply_stimulus(1'b1, sweep_q[k]);
            else apply_stimulus(1'b0, 0);
            if (sin_cos_valid !== (k >= L)) bad_valid = 1;
            if (k >= L) begin
                real ang;
                ang = real'(sweep_q[k-L]) / 8192.0;
                check_output($sformatf("sweep_cos_ph%0d", sweep_q[k-L]), cos_val, round_real($cos(ang) * 16384.0), 4);
                check_output($sformatf("sweep_sin_ph%0d", sweep_q[k-L]), sin_val, round_real($sin(ang) * 16384.0), 4);
            end
        end
        check_output("sweep_valid_continuous", bad_valid, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
